shift_and_subtract_divider: RTL
===============================

SHIFT_AND_SUBTRACT_DIVIDER -- requirements
Module: shift_and_subtract_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand, quotient and remainder width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port inpA  input  WIDTH  dividend (unsigned).
REQ-006 SHALL have port inpB  input  WIDTH  divisor (unsigned).
REQ-007 SHALL have port Q  output  WIDTH  quotient register.
REQ-008 SHALL have port R  output  WIDTH  remainder register.
REQ-009 SHALL have port busy  output  1  high while the FSM is in RUN.
REQ-010 SHALL have port done  output  1  one-cycle pulse when Q and R are valid.

Function
REQ-011 SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-012 SHALL, in IDLE with start=1, load the dividend into the quotient shift register, load the divisor into M, clear a WIDTH+1-bit partial remainder, clear the step counter, and enter RUN.
REQ-013 SHALL, in each RUN cycle, shift {remainder, quotient} left by one and form trial = shifted remainder - M over WIDTH+1 bits.
REQ-014 SHALL, in each RUN cycle, keep trial as the new remainder and set quotient LSB to 1 when trial is non-negative; otherwise it SHALL restore the remainder and set quotient LSB to 0.
REQ-015 SHALL leave RUN after exactly WIDTH iterations and enter DONE.
REQ-016 SHALL assert done for exactly one cycle in DONE and then return to IDLE.
REQ-017 SHALL have a latency, from the rising edge sampling start to the rising edge on which done is seen high, of WIDTH+1 cycles.
REQ-018 SHALL hold Q and R stable from DONE until the next accepted start.
REQ-019 SHALL ignore start while in RUN or DONE; the inputs SHALL be captured only when start is accepted.
REQ-020 SHALL accept start in the cycle immediately after done, giving back-to-back operation.
REQ-021 SHALL satisfy inpA = Q*inpB + R and R < inpB for every inpB != 0.
REQ-022 SHALL, for inpB = 0 with the configuration macro undefined, run the full WIDTH cycles and produce Q = all ones and R = inpA.

Reset
REQ-023 SHALL, when rst=1, immediately force the FSM to IDLE and set Q=0, R=0, busy=0, done=0, the step counter to 0 and M to 0, regardless of clk.
REQ-024 SHALL abort any operation in progress on assertion of rst, with no done pulse generated.

Configuration
REQ-025 SHALL, when DIV_BY_ZERO_DETECT_EN is defined, add output port dbz (1 bit).
REQ-026 SHALL, when DIV_BY_ZERO_DETECT_EN is defined and start is accepted with inpB = 0, go IDLE->DONE directly, set Q = all ones and R = inpA, and assert dbz together with done.
REQ-027 SHALL, when DIV_BY_ZERO_DETECT_EN is defined, hold dbz until the next accepted start, and reset dbz to 0 on rst.
REQ-028 SHALL, when DIV_BY_ZERO_DETECT_EN is undefined, have no dbz port and use the behaviour of REQ-022.

Structure
REQ-029 SHALL take the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default width constant from shared package divider_pkg.
REQ-030 SHALL perform the trial subtraction in a single sub-module, four_bit_subtractor (WIDTH+1 bits, outputs difference and borrow); all other logic stays in the top module.

Verification
REQ-031 SHALL cover: 13/4 -> Q=3, R=1, done high 5 cycles after start, busy high for 4 cycles.
REQ-032 SHALL cover: 15/1 -> Q=15, R=0; then 3/7 started the cycle after done -> Q=0, R=3.
REQ-033 SHALL cover: 9/0 -> Q=15, R=9; with the macro, done after 1 cycle and dbz=1; without it, done after 5 cycles.
REQ-034 SHALL cover: start=1 pulsed during RUN with different operands -> the result matches the first operands only.
REQ-035 SHALL cover: rst asserted mid-RUN, between clock edges -> outputs zero immediately, no done pulse, and the next 12/5 gives Q=2, R=2.
REQ-036 SHALL cover: exhaustive 4-bit sweep of all 256 operand pairs, self-checked against REQ-021 and REQ-022.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the shift-and-subtract divider:
// the FSM state encoding and the default operand width.
`timescale 1ns/1ps
package divider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/four_bit_subtractor.sv
// Trial subtractor for the divider. It computes diff = a - b and raises
// borrow when the result would be negative.
`timescale 1ns/1ps
module four_bit_subtractor #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    // Zero-extend by one bit so the extra top bit carries the borrow out.
    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/shift_and_subtract_divider.sv
// Restoring shift-and-subtract unsigned divider that takes WIDTH iterations.
// Optional macro DIV_BY_ZERO_DETECT_EN adds a dbz flag and a fast path for a zero divisor.
`timescale 1ns/1ps
module shift_and_subtract_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] inpA,
    input  logic [WIDTH-1:0] inpB,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done
`ifdef DIV_BY_ZERO_DETECT_EN
    ,
    output logic             dbz
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t           state_r, state_s;
    logic [WIDTH-1:0] quo_r, quo_s;
    logic [WIDTH-1:0] m_r, m_s;
    logic [WIDTH:0]   rem_r, rem_s;
    logic [WIDTH:0]   shifted_s, trial_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             borrow_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             dbz_r, dbz_s;
    logic             unused_s;

    // The quotient MSB moves into the remainder as the pair shifts left by one.
    assign shifted_s = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
    assign unused_s  = rem_r[WIDTH];

    four_bit_subtractor #(.W(WIDTH + 1)) u_sub (
        .a      (shifted_s),
        .b      ({1'b0, m_r}),
        .diff   (trial_s),
        .borrow (borrow_s)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_s = state_r;
        quo_s   = quo_r;
        m_s     = m_r;
        rem_s   = rem_r;
        cnt_s   = cnt_r;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        dbz_s   = dbz_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    m_s   = inpB;
                    cnt_s = {CW{1'b0}};
`ifdef DIV_BY_ZERO_DETECT_EN
                    if (inpB == {WIDTH{1'b0}}) begin
                        quo_s   = {WIDTH{1'b1}};
                        rem_s   = {1'b0, inpA};
                        dbz_s   = 1'b1;
                        done_s  = 1'b1;
                        state_s = DONE;
                    end else begin
                        quo_s   = inpA;
                        rem_s   = {(WIDTH+1){1'b0}};
                        dbz_s   = 1'b0;
                        busy_s  = 1'b1;
                        state_s = RUN;
                    end
`else
                    quo_s   = inpA;
                    rem_s   = {(WIDTH+1){1'b0}};
                    busy_s  = 1'b1;
                    state_s = RUN;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                // A borrow means the trial went negative, so the shifted remainder is restored.
                quo_s = {quo_r[WIDTH-2:0], ~borrow_s};
                rem_s = borrow_s ? shifted_s : trial_s;
                cnt_s = cnt_r + CNT_ONE;
                if (cnt_r == LAST_STEP) begin
                    done_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    busy_s  = 1'b1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_r  <= {WIDTH{1'b0}};
            m_r    <= {WIDTH{1'b0}};
            rem_r  <= {(WIDTH+1){1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            quo_r  <= quo_s;
            m_r    <= m_s;
            rem_r  <= rem_s;
            cnt_r  <= cnt_s;
            busy_r <= busy_s;
            done_r <= done_s;
            dbz_r  <= dbz_s;
        end
    end

    assign Q    = quo_r;
    assign R    = rem_r[WIDTH-1:0];
    assign busy = busy_r;
    assign done = done_r;
`ifdef DIV_BY_ZERO_DETECT_EN
    assign dbz  = dbz_r;
`endif

endmodule
